// File: rtl/fifo_read_drain.sv
// Read-side drain for the async FIFO: credit-limited reads into a 2-entry skid
// buffer, a valid/ready output stream, a delivered-word counter and an incrementing-sequence check.
module fifo_read_drain #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned SEQ_START = 1
) (
    input  logic              rd_clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    input  logic              enable,
    input  logic              clr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  word_count,
    output logic              seq_err,
    output logic              busy
);

    localparam int unsigned OCC_W = 2;
    localparam int unsigned SUM_W = 3;

    logic [OCC_W-1:0]  occ;
    logic              inflight;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tail;
    logic [DATA_W-1:0] expected;
    logic              pop;
    logic              push;
    logic [SUM_W-1:0]  credit_used;

    assign pop     = m_valid && m_ready;
    assign push    = inflight;
    assign m_valid = (occ != OCC_W'(0));
    assign m_data  = head;
    assign busy    = m_valid || inflight;

    // Slots still committed after this edge's pop; a read needs one to be free.
    assign credit_used = SUM_W'(occ) + SUM_W'(inflight) - SUM_W'(pop);

    always_comb begin
        fifo_rd_en = 1'b0;
        if (!rst && enable && !fifo_empty && (credit_used < SUM_W'(2))) begin
            fifo_rd_en = 1'b1;
        end
    end

    // Read latency is one cycle, so an accepted read returns data next edge.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            occ      <= '0;
        end else begin
            inflight <= fifo_rd_en;
            occ      <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Two-entry buffer kept as head/tail; a pop shifts tail into head.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else if (pop) begin
            if (occ == OCC_W'(2)) begin
                head <= tail;
                if (push) begin
                    tail <= fifo_dout;
                end
            end else if (push) begin
                head <= fifo_dout;
            end
        end else if (push) begin
            if (occ == OCC_W'(0)) begin
                head <= fifo_dout;
            end else begin
                tail <= fifo_dout;
            end
        end
    end

    // Count and sequence check; clr beats a coincident pop.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            word_count <= '0;
            seq_err    <= 1'b0;
            expected   <= DATA_W'(SEQ_START);
        end else if (clr) begin
            word_count <= '0;
            seq_err    <= 1'b0;
            expected   <= DATA_W'(SEQ_START);
        end else if (pop) begin
            word_count <= word_count + CNT_W'(1);
            if (head != expected) begin
                seq_err <= 1'b1;
            end
            expected <= head + DATA_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_read_drain.sv
// Bench for fifo_read_drain: a queue-based FIFO source and drain model compared
// against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_fifo_read_drain;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned SEQ_START = 1;

    logic              rd_clk = 1'b0;
    logic              rst;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_rd_en;
    logic              enable;
    logic              clr;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [CNT_W-1:0]  word_count;
    logic              seq_err;
    logic              busy;

    always #5 rd_clk = ~rd_clk;

    fifo_read_drain #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SEQ_START(SEQ_START)) dut (
        .rd_clk(rd_clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .enable(enable), .clr(clr), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .word_count(word_count),
        .seq_err(seq_err), .busy(busy)
    );

    // Source FIFO contents and drain model state.
    logic [DATA_W-1:0] src[$];
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] log_q[$];
    logic              m_inflight;
    logic [DATA_W-1:0] m_inflight_word;
    int                m_cnt;
    logic              m_err;
    logic [DATA_W-1:0] m_exp;
    logic              exp_pop;
    logic              exp_rd;
    int                checks;
    int                errors;
    int                dut_rd_pulses;
    int                n_pops;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_inflight = 1'b0;
        m_cnt      = 0;
        m_err      = 1'b0;
        m_exp      = DATA_W'(SEQ_START);
    endtask

    // Per-cycle comparison of every DUT output against the model.
    task automatic compare();
        int depth;
        depth   = mq.size() + (m_inflight ? 1 : 0);
        exp_pop = (mq.size() != 0) && m_ready;
        exp_rd  = enable && !fifo_empty && ((depth - (exp_pop ? 1 : 0)) < 2);
        check("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
        check("m_valid", 32'(m_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) check("m_data", 32'(m_data), 32'(mq[0]));
        check("word_count", 32'(word_count), 32'(m_cnt));
        check("seq_err", 32'(seq_err), 32'(m_err));
        check("busy", 32'(busy), 32'(depth != 0));
        check("credit", 32'((int'(dut.occ) + int'(dut.inflight)) <= 2), 32'(1));
        check("rd_while_empty", 32'(fifo_rd_en && fifo_empty), 32'(0));
        if (fifo_rd_en) dut_rd_pulses++;
    endtask

    task automatic advance();
        logic [DATA_W-1:0] d;
        d = '0;
        if (exp_pop) begin
            d = mq.pop_front();
            log_q.push_back(d);
            n_pops++;
        end
        if (clr) begin
            m_cnt = 0;
            m_err = 1'b0;
            m_exp = DATA_W'(SEQ_START);
        end else if (exp_pop) begin
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (d != m_exp) m_err = 1'b1;
            m_exp = d + DATA_W'(1);
        end
        if (m_inflight) mq.push_back(m_inflight_word);
        m_inflight = exp_rd;
        if (exp_rd) m_inflight_word = src.pop_front();
    endtask

    task automatic cycle(input logic en, input logic rdy, input logic cl);
        enable     = en;
        m_ready    = rdy;
        clr        = cl;
        fifo_empty = (src.size() == 0);
        #1;
        compare();
        advance();
        @(posedge rd_clk);
        #1;
        fifo_dout = m_inflight ? m_inflight_word : DATA_W'($urandom);
    endtask

    task automatic push_range(input int first, input int n);
        for (int i = 0; i < n; i++) src.push_back(DATA_W'(first + i));
    endtask

    task automatic drain(input int max_cycles, input logic rnd_ready);
        int k;
        k = 0;
        while ((src.size() != 0 || mq.size() != 0 || m_inflight) && k < max_cycles) begin
            cycle(1'b1, rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1, 1'b0);
            k++;
        end
        check("drain_timeout", 32'(k < max_cycles), 32'(1));
        cycle(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        int base_rd;
        int base_pops;
        int k;
        logic [DATA_W-1:0] nxt;
        checks = 0; errors = 0; dut_rd_pulses = 0; n_pops = 0;
        rst = 1'b0; enable = 1'b0; clr = 1'b0; m_ready = 1'b0;
        fifo_empty = 1'b1; fifo_dout = '0;
        model_reset();
        #1 rst = 1'b1;
        #2;
        check("reset_m_valid", 32'(m_valid), 32'(0));
        check("reset_m_data", 32'(m_data), 32'(0));
        check("reset_rd_en", 32'(fifo_rd_en), 32'(0));
        check("reset_count", 32'(word_count), 32'(0));
        check("reset_seq_err", 32'(seq_err), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        #9 rst = 1'b0;
        @(posedge rd_clk);
        #1;

        // Basic drain at full throughput: words appear on cycles 2..9.
        push_range(1, 8);
        base_rd = dut_rd_pulses;
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0);
        check("basic_count", 32'(word_count), 32'(8));
        check("basic_reads", 32'(dut_rd_pulses - base_rd), 32'(8));
        check("basic_seq_err", 32'(seq_err), 32'(0));
        for (int i = 0; i < 8; i++) check("basic_word", 32'(log_q[i]), 32'(i + 1));
        cycle(1'b1, 1'b1, 1'b0);
        check("basic_busy", 32'(busy), 32'(0));

        // Backpressure with ready pattern 1,0,0,1.
        push_range(9, 8);
        for (int i = 0; i < 40; i++) cycle(1'b1, (i % 4 == 0) || (i % 4 == 3), 1'b0);
        check("bp_count", 32'(word_count), 32'(16));
        check("bp_seq_err", 32'(seq_err), 32'(0));
        check("bp_busy", 32'(busy), 32'(0));

        // Enable drop after the third read.
        push_range(17, 8);
        base_rd = dut_rd_pulses;
        base_pops = n_pops;
        k = 0;
        while ((dut_rd_pulses - base_rd) < 3 && k < 20) begin
            cycle(1'b1, 1'b1, 1'b0);
            k++;
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0);
        check("endrop_reads", 32'(dut_rd_pulses - base_rd), 32'(3));
        check("endrop_pops", 32'(n_pops - base_pops), 32'(3));
        check("endrop_busy", 32'(busy), 32'(0));
        check("endrop_count", 32'(word_count), 32'(19));
        drain(100, 1'b0);
        check("reenable_count", 32'(word_count), 32'(24));
        check("reenable_seq_err", 32'(seq_err), 32'(0));

        // Sequence gap 1,2,4,5 then clr.
        cycle(1'b1, 1'b1, 1'b1);
        check("clr_count", 32'(word_count), 32'(0));
        src.push_back(8'd1); src.push_back(8'd2); src.push_back(8'd4); src.push_back(8'd5);
        drain(100, 1'b0);
        check("gap_seq_err", 32'(seq_err), 32'(1));
        check("gap_count", 32'(word_count), 32'(4));
        cycle(1'b1, 1'b1, 1'b1);
        check("gap_clr_seq_err", 32'(seq_err), 32'(0));
        check("gap_clr_count", 32'(word_count), 32'(0));

        // clr coincident with the pop of word 5; word 6 then mismatches.
        push_range(1, 6);
        k = 0;
        while ((src.size() != 0 || mq.size() != 0 || m_inflight) && k < 40) begin
            cycle(1'b1, 1'b1, (mq.size() != 0) && (mq[0] == DATA_W'(5)));
            k++;
        end
        check("collide_count", 32'(word_count), 32'(1));
        check("collide_seq_err", 32'(seq_err), 32'(1));
        cycle(1'b1, 1'b1, 1'b1);

        // Data wrap 255 -> 0 is in sequence; counter wraps at 2^CNT_W.
        push_range(1, 258);
        drain(2000, 1'b1);
        check("wrap_seq_err", 32'(seq_err), 32'(0));
        check("wrap_count", 32'(word_count), 32'(258 % 64));

        // Randomized traffic.
        nxt = DATA_W'(SEQ_START);
        cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                src.push_back(($urandom_range(0, 19) == 0) ? DATA_W'($urandom) : nxt);
                nxt = nxt + DATA_W'(1);
            end
            cycle($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
        end
        drain(500, 1'b0);

        // Asynchronous reset with two words buffered.
        cycle(1'b1, 1'b1, 1'b1);
        push_range(1, 6);
        k = 0;
        while (mq.size() < 2 && k < 20) begin
            cycle(1'b1, 1'b0, 1'b0);
            k++;
        end
        check("rst_occ_full", 32'(dut.occ), 32'(2));
        enable = 1'b1; m_ready = 1'b0; clr = 1'b0;
        fifo_empty = (src.size() == 0);
        #1;
        compare();
        #2 rst = 1'b1;
        #1;
        check("midrst_m_valid", 32'(m_valid), 32'(0));
        check("midrst_rd_en", 32'(fifo_rd_en), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_m_data", 32'(m_data), 32'(0));
        model_reset();
        @(posedge rd_clk);
        #1;
        fifo_dout = DATA_W'($urandom);
        #2 rst = 1'b0;
        check("midrst_count", 32'(word_count), 32'(0));
        drain(100, 1'b0);
        check("midrst_resume_seq_err", 32'(seq_err), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
